riscv_dual_fetch_mem_responder: RTL and testbench
=================================================

// Module: riscv_dual_fetch_mem_responder
// PURPOSE
//  Memory-side responder for the dual-fetch RISCV core: services imemreq0, imemreq1 and dmemreq
//  against one shared word-addressed array. Returns responses on the matching resp ports after a
//  fixed latency. Responses are strictly in order per port. Sits in the test harness/top opposite riscv_Core.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words in the array; word index = addr[31:2] modulo DEPTH.
//  LATENCY  2     cycles from request accept to resp_val; legal range 1..8.
// PORTS
//  clk            in   1   clock, rising edge.
//  reset          in   1   asynchronous, active-low reset.
//  imemreq0_msg   in   67  {type[66], addr[65:34], len[33:32], data[31:0]}; type is ignored, always a read.
//  imemreq0_val   in   1   request valid.
//  imemreq0_rdy   out  1   request ready.
//  imemresp0_msg  out  35  {type[34], len[33:32], data[31:0]}.
//  imemresp0_val  out  1   response valid; the core has no resp_rdy.
//  imemreq1_*/imemresp1_*  same widths and meaning as port 0.
//  dmemreq_msg    in   67  same layout; type 0=read, 1=write; len 0=word, 1=byte, 2=half, 3=3 bytes.
//  dmemreq_val / dmemreq_rdy / dmemresp_msg / dmemresp_val   as above.
//  host_wen       in   1   harness preload write enable.
//  host_waddr     in   32  preload byte address; word aligned.
//  host_wdata     in   32  preload data.
//  oob_err        out  1   sticky flag: set on any access with addr[31:2] >= DEPTH.
// BEHAVIOUR
//  - Reset (reset==0): all *_rdy, *_resp_val and oob_err go 0 immediately. All in-flight responses are
//    flushed and dropped. Array contents are NOT cleared.
//  - *_rdy = 1 on every cycle the block is out of reset. There is no backpressure, because responses
//    cannot be stalled. A request is accepted on a rising edge with val && rdy.
//  - Each port has an independent LATENCY-deep shift pipeline of {val, type, len, data}.
//    Response for an accept at edge N appears with val=1 during the cycle after edge N+LATENCY-1.
//    (LATENCY=1: visible the cycle right after accept.) One response per accept, no reordering.
//    Back-to-back accepts give back-to-back responses.
//  - Reads: the word is sampled at the accept edge. Sub-word loads shift the word right by 8*addr[1:0]
//    and zero-extend to len bytes; the core does the sign extension. Word reads ignore addr[1:0].
//  - Writes (dmem only): byte enables derive from len and addr[1:0]. data[7:0] goes to byte addr[1:0].
//    Bytes beyond byte 3 are dropped. The write commits at the accept edge.
//    Write response: type=1, len echoed, data=0.
//  - Same-edge ordering: imem0/imem1 and dmem reads return the pre-write value. A dmem write and a
//    host write to the same word: host write wins. Host writes may occur at any time and get no response.
//  - Out-of-range address: reads return data 0, writes are dropped, the response is still produced
//    with normal latency, and oob_err is set. oob_err is cleared only by reset.
//  - Response type/len echo the request. imem responses always have type=0, len=0.
//  - A port with imem addr[1:0]!=0 returns the aligned word; no error is raised.
// TESTING
//  1. Preload word 0x100=0xDEADBEEF. imemreq0 and imemreq1 both read 0x100 on the same edge
//     -> both resp_val exactly LATENCY cycles later, data=0xDEADBEEF.
//  2. dmem write len=1 addr=0x101 data=0xAA, then a word read of 0x100 on the next edge
//     -> the read returns 0xDEADAAEF. The write response data is 0.
//  3. dmem write word 0x200=0x12345678 and imemreq0 read 0x200 on the same edge -> imem returns the old value.
//     An imem read of 0x200 on the next edge returns 0x12345678.
//  4. imemreq0 accepts 8 back-to-back reads of 0x0,0x4,...,0x1C -> 8 consecutive resp_val cycles,
//     data in the same order.
//  5. Read addr = 4*DEPTH -> data 0, oob_err=1 and stays 1 until reset.
//  6. Assert reset mid-flight with 2 responses pending -> resp_val drops at once, no stale responses
//     after release, preloaded array data retained.

Source files
------------

// File: rtl/riscv_dual_fetch_mem_responder.sv
// ---------------------------------------------------------------------------
// riscv_dual_fetch_mem_responder
//
// Memory-side responder for the dual-fetch RISC-V core. Two instruction fetch
// ports (imem0, imem1) and one data port (dmem) share a single word-addressed
// array of DEPTH 32-bit words. Every accepted request produces exactly one
// response, LATENCY cycles later, on the matching response port. Responses on
// each port come back in request order.
//
// Ports
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low reset
//   imemreq{0,1}_msg  [66:0]    {type, addr[31:0], len[1:0], data[31:0]}
//                               (type ignored, always a read)
//   imemreq{0,1}_val / _rdy     request handshake (rdy is 1 whenever out of reset)
//   imemresp{0,1}_msg [34:0]    {type, len[1:0], data[31:0]}; always type=0, len=0
//   imemresp{0,1}_val           response valid (no ready: responses cannot stall)
//   dmemreq_msg       [66:0]    same layout; type 0=read 1=write;
//                               len 0=word 1=byte 2=half 3=three bytes
//   dmemreq_val / dmemreq_rdy   request handshake
//   dmemresp_msg      [34:0]    type/len echoed; read data zero-extended,
//                               write responses carry data 0
//   dmemresp_val                response valid
//   host_wen/host_waddr/host_wdata  harness preload write port, no response
//   oob_err                     sticky: some request addressed a word >= DEPTH
// ---------------------------------------------------------------------------
module riscv_dual_fetch_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [66:0] imemreq0_msg,
  input  logic        imemreq0_val,
  output logic        imemreq0_rdy,
  output logic [34:0] imemresp0_msg,
  output logic        imemresp0_val,

  input  logic [66:0] imemreq1_msg,
  input  logic        imemreq1_val,
  output logic        imemreq1_rdy,
  output logic [34:0] imemresp1_msg,
  output logic        imemresp1_val,

  input  logic [66:0] dmemreq_msg,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  output logic [34:0] dmemresp_msg,
  output logic        dmemresp_val,

  input  logic        host_wen,
  input  logic [31:0] host_waddr,
  input  logic [31:0] host_wdata,

  output logic        oob_err
);

  localparam int NP = 3;   // port 0 = imem0, 1 = imem1, 2 = dmem
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] widx;
    widx = {2'b00, addr[31:2]};
    return widx < 32'(DEPTH);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return addr[AW+1:2];
  endfunction

  // Sub-word load: shift the selected byte down to bit 0 and zero-extend to
  // len bytes. A word load (len 0) ignores the byte offset entirely.
  function automatic logic [31:0] subword(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [1:0]  len);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (len)
      2'd1:    return {24'd0, sh[7:0]};
      2'd2:    return {16'd0, sh[15:0]};
      2'd3:    return {8'd0,  sh[23:0]};
      default: return word;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Port bundling so the per-port logic can be generated uniformly
  // -------------------------------------------------------------------------
  logic [66:0]   req_msg  [NP];
  logic [NP-1:0] req_val;
  logic [34:0]   resp_msg [NP];
  logic [NP-1:0] resp_val;
  logic [NP-1:0] oob_hit;

  assign req_msg[0] = imemreq0_msg;
  assign req_msg[1] = imemreq1_msg;
  assign req_msg[2] = dmemreq_msg;
  assign req_val    = {dmemreq_val, imemreq1_val, imemreq0_val};

  assign imemresp0_msg = resp_msg[0];
  assign imemresp1_msg = resp_msg[1];
  assign dmemresp_msg  = resp_msg[2];
  assign imemresp0_val = resp_val[0];
  assign imemresp1_val = resp_val[1];
  assign dmemresp_val  = resp_val[2];

  // Responses cannot be stalled, so requests are never back-pressured.
  // Ready follows reset combinationally so it drops the instant reset asserts.
  assign imemreq0_rdy = reset;
  assign imemreq1_rdy = reset;
  assign dmemreq_rdy  = reset;

  // -------------------------------------------------------------------------
  // Shared storage (contents survive reset)
  // -------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Per-port read path and response pipeline
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    logic [31:0] addr;
    logic        type_f;
    logic [1:0]  len_f;
    logic        in_rng;
    logic        acc;
    logic [31:0] word;
    logic [31:0] rdata;
    logic [34:0] pay_new;
    logic [LATENCY-1:0] val_q;
    logic [LATENCY:0]   val_ext;
    logic [34:0]        pay_q [LATENCY];

    assign addr = req_msg[gi][65:34];

    if (gi == NP - 1) begin : g_dmem
      assign type_f = req_msg[gi][66];
      assign len_f  = req_msg[gi][33:32];
    end else begin : g_imem
      // Fetch ports are always word reads; type/len/data of the request are
      // don't-cares and the response echoes type=0, len=0.
      logic unused_imem;
      assign unused_imem = ^{req_msg[gi][66], req_msg[gi][33:0]};
      assign type_f = 1'b0;
      assign len_f  = 2'd0;
    end

    assign in_rng = addr_in_range(addr);
    assign acc    = req_val[gi] & reset;

    // Read sees the array before any write committing on the same edge,
    // because the sample below and the array update are both non-blocking.
    assign word    = in_rng ? mem_q[word_idx(addr)] : 32'd0;
    assign rdata   = subword(word, addr[1:0], len_f);
    assign pay_new = {type_f, len_f, type_f ? 32'd0 : rdata};

    assign oob_hit[gi] = acc & ~in_rng;

    // Valid bits are the only flushed state; payloads behind a cleared
    // valid are never observed.
    assign val_ext = {val_q, acc};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= '0;
      end else begin
        val_q <= val_ext[LATENCY-1:0];
      end
    end

    always_ff @(posedge clk) begin
      pay_q[0] <= pay_new;
      for (int s = 1; s < LATENCY; s++) begin
        pay_q[s] <= pay_q[s-1];
      end
    end

    assign resp_val[gi] = val_q[LATENCY-1];
    assign resp_msg[gi] = pay_q[LATENCY-1];
  end

  // -------------------------------------------------------------------------
  // Write path: dmem stores and host preload
  // -------------------------------------------------------------------------
  logic [31:0] w_addr;
  logic [1:0]  w_off;
  logic [1:0]  w_len;
  logic [2:0]  w_nbytes;
  logic [7:0]  w_be_wide;
  logic [3:0]  w_be;
  logic [31:0] w_data;
  logic        dmem_wr;
  logic        host_wr;

  assign w_addr   = req_msg[2][65:34];
  assign w_off    = w_addr[1:0];
  assign w_len    = req_msg[2][33:32];
  assign w_nbytes = (w_len == 2'd0) ? 3'd4 : {1'b0, w_len};
  // Byte lanes starting at the byte offset; lanes past byte 3 fall off the
  // top of the word and are discarded.
  assign w_be_wide = ((8'd1 << w_nbytes) - 8'd1) << w_off;
  assign w_be      = w_be_wide[3:0];
  assign w_data    = req_msg[2][31:0] << {w_off, 3'b000};

  assign dmem_wr = dmemreq_val & reset & req_msg[2][66] & addr_in_range(w_addr);
  assign host_wr = host_wen & addr_in_range(host_waddr);

  logic unused_w;
  assign unused_w = ^{w_be_wide[7:4], host_waddr[1:0]};

  // Host write is issued after the dmem write so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (dmem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[word_idx(w_addr)][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
    if (host_wr) begin
      mem_q[word_idx(host_waddr)] <= host_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky out-of-range flag
  // -------------------------------------------------------------------------
  logic oob_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_err_q <= 1'b0;
    end else if (|oob_hit) begin
      oob_err_q <= 1'b1;
    end
  end

  assign oob_err = oob_err_q;

endmodule

// File: tb/tb_riscv_dual_fetch_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for riscv_dual_fetch_mem_responder. Directed stimulus in one
// initial block; expected responses are queued per port when a request is
// driven (from a byte-level reference memory) and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_riscv_dual_fetch_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;

  logic [66:0] imemreq0_msg = '0;
  logic        imemreq0_val = 1'b0;
  logic        imemreq0_rdy;
  logic [34:0] imemresp0_msg;
  logic        imemresp0_val;
  logic [66:0] imemreq1_msg = '0;
  logic        imemreq1_val = 1'b0;
  logic        imemreq1_rdy;
  logic [34:0] imemresp1_msg;
  logic        imemresp1_val;
  logic [66:0] dmemreq_msg = '0;
  logic        dmemreq_val = 1'b0;
  logic        dmemreq_rdy;
  logic [34:0] dmemresp_msg;
  logic        dmemresp_val;
  logic        host_wen   = 1'b0;
  logic [31:0] host_waddr = '0;
  logic [31:0] host_wdata = '0;
  logic        oob_err;

  riscv_dual_fetch_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .imemreq0_msg  (imemreq0_msg),
    .imemreq0_val  (imemreq0_val),
    .imemreq0_rdy  (imemreq0_rdy),
    .imemresp0_msg (imemresp0_msg),
    .imemresp0_val (imemresp0_val),
    .imemreq1_msg  (imemreq1_msg),
    .imemreq1_val  (imemreq1_val),
    .imemreq1_rdy  (imemreq1_rdy),
    .imemresp1_msg (imemresp1_msg),
    .imemresp1_val (imemresp1_val),
    .dmemreq_msg   (dmemreq_msg),
    .dmemreq_val   (dmemreq_val),
    .dmemreq_rdy   (dmemreq_rdy),
    .dmemresp_msg  (dmemresp_msg),
    .dmemresp_val  (dmemresp_val),
    .host_wen      (host_wen),
    .host_waddr    (host_waddr),
    .host_wdata    (host_wdata),
    .oob_err       (oob_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [34:0] msg;
  } exp_t;

  exp_t        sbq [3][$];
  logic [31:0] model_mem [DEPTH];
  logic        exp_oob = 1'b0;
  int          edge_n  = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;

  function automatic logic [66:0] mk(input logic t, input logic [31:0] a,
                                     input logic [1:0] l, input logic [31:0] d);
    return {t, a, l, d};
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return a[31:2] >= DEPTH;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] l,
                                             input bit imem);
    logic [31:0] w;
    logic [31:0] r;
    int          off;
    if (is_oob(a)) return 32'd0;
    w = model_mem[int'(a[31:2])];
    if (imem || l == 2'd0) return w;
    off = int'(a[1:0]);
    r = 32'd0;
    for (int i = 0; i < int'(l); i++) begin
      if (off + i < 4) r[8*i +: 8] = w[8*(off+i) +: 8];
    end
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    int n;
    int off;
    logic [31:0] w;
    if (is_oob(a)) return;
    n   = (l == 2'd0) ? 4 : int'(l);
    off = int'(a[1:0]);
    w   = model_mem[int'(a[31:2])];
    for (int i = 0; i < n; i++) begin
      if (off + i < 4) w[8*(off+i) +: 8] = d[8*i +: 8];
    end
    model_mem[int'(a[31:2])] = w;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0]  rv;
    logic [2:0]  rdy;
    logic [34:0] rm [3];
    bit          ev;
    rv    = {dmemresp_val, imemresp1_val, imemresp0_val};
    rdy   = {dmemreq_rdy, imemreq1_rdy, imemreq0_rdy};
    rm[0] = imemresp0_msg;
    rm[1] = imemresp1_msg;
    rm[2] = dmemresp_msg;
    for (int p = 0; p < 3; p++) begin
      ev = (sbq[p].size() > 0) && (sbq[p][0].due == edge_n);
      check($sformatf("p%0d_rdy@%0d", p, edge_n), 64'(rdy[p]), 64'(reset));
      check($sformatf("p%0d_val@%0d", p, edge_n), 64'(rv[p]), 64'(ev));
      if (ev) begin
        check($sformatf("p%0d_msg@%0d", p, edge_n), 64'(rm[p]), 64'(sbq[p][0].msg));
        void'(sbq[p].pop_front());
      end
    end
    check($sformatf("oob@%0d", edge_n), 64'(oob_err), 64'(exp_oob));
  endtask

  // Queue expectations for whatever is driven, clock once, then check.
  task automatic cycle();
    int          due;
    logic [31:0] a;
    logic [1:0]  l;
    if (reset) begin
      due = edge_n + LAT;
      if (imemreq0_val) begin
        a = imemreq0_msg[65:34];
        sbq[0].push_back('{due, {3'b000, model_read(a, 2'd0, 1'b1)}});
        if (is_oob(a)) exp_oob = 1'b1;
      end
      if (imemreq1_val) begin
        a = imemreq1_msg[65:34];
        sbq[1].push_back('{due, {3'b000, model_read(a, 2'd0, 1'b1)}});
        if (is_oob(a)) exp_oob = 1'b1;
      end
      if (dmemreq_val) begin
        a = dmemreq_msg[65:34];
        l = dmemreq_msg[33:32];
        if (is_oob(a)) exp_oob = 1'b1;
        if (dmemreq_msg[66]) begin
          sbq[2].push_back('{due, {1'b1, l, 32'd0}});
          model_write(a, l, dmemreq_msg[31:0]);
        end else begin
          sbq[2].push_back('{due, {1'b0, l, model_read(a, l, 1'b0)}});
        end
      end
    end
    if (host_wen && !is_oob(host_waddr)) model_mem[int'(host_waddr[31:2])] = host_wdata;
    @(posedge clk);
    edge_n++;
    #1;
    imemreq0_val = 1'b0;
    imemreq1_val = 1'b0;
    dmemreq_val  = 1'b0;
    host_wen     = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic host_load(input logic [31:0] a, input logic [31:0] d);
    host_wen   = 1'b1;
    host_waddr = a;
    host_wdata = d;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;

    // Reset state
    #1 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);

    // Preload
    host_load(32'h100, 32'hDEADBEEF);
    host_load(32'h200, 32'h0BADF00D);
    host_load(32'h300, 32'h00000000);
    for (int i = 0; i < 8; i++) host_load(32'(4*i), 32'hA5000000 | 32'(i * 32'h111));

    // Both fetch ports read the same word on the same edge
    imemreq0_msg = mk(1'b0, 32'h100, 2'd0, 32'd0); imemreq0_val = 1'b1;
    imemreq1_msg = mk(1'b1, 32'h100, 2'd3, 32'hFFFF); imemreq1_val = 1'b1;
    cycle();
    idle(LAT);

    // Byte store then loads of varying width
    dmemreq_msg = mk(1'b1, 32'h101, 2'd1, 32'hAA); dmemreq_val = 1'b1; cycle();
    dmemreq_msg = mk(1'b0, 32'h100, 2'd0, 32'd0);  dmemreq_val = 1'b1; cycle();
    dmemreq_msg = mk(1'b0, 32'h102, 2'd1, 32'd0);  dmemreq_val = 1'b1; cycle();
    dmemreq_msg = mk(1'b0, 32'h102, 2'd2, 32'd0);  dmemreq_val = 1'b1; cycle();
    dmemreq_msg = mk(1'b0, 32'h101, 2'd3, 32'd0);  dmemreq_val = 1'b1; cycle();
    idle(LAT);

    // Host write beats dmem write to the same word; misaligned half store truncates
    dmemreq_msg = mk(1'b1, 32'h300, 2'd0, 32'h11111111); dmemreq_val = 1'b1;
    host_wen = 1'b1; host_waddr = 32'h300; host_wdata = 32'h22222222;
    cycle();
    dmemreq_msg = mk(1'b1, 32'h303, 2'd2, 32'hBBCC); dmemreq_val = 1'b1; cycle();
    dmemreq_msg = mk(1'b0, 32'h300, 2'd0, 32'd0);    dmemreq_val = 1'b1; cycle();
    idle(LAT);

    // Same-edge store and fetch: fetch sees the old word
    dmemreq_msg  = mk(1'b1, 32'h200, 2'd0, 32'h12345678); dmemreq_val = 1'b1;
    imemreq0_msg = mk(1'b0, 32'h200, 2'd0, 32'd0);        imemreq0_val = 1'b1;
    cycle();
    imemreq0_msg = mk(1'b0, 32'h200, 2'd0, 32'd0); imemreq0_val = 1'b1;
    cycle();
    idle(LAT);

    // Back-to-back fetches; port 1 uses misaligned addresses
    for (int i = 0; i < 8; i++) begin
      imemreq0_msg = mk(1'b0, 32'(4*i), 2'd0, 32'd0);         imemreq0_val = 1'b1;
      imemreq1_msg = mk(1'b0, 32'h100 + 32'(i % 4), 2'd0, 32'd0); imemreq1_val = 1'b1;
      cycle();
    end
    idle(LAT);

    // Out-of-range accesses
    imemreq1_msg = mk(1'b0, 32'(4*DEPTH), 2'd0, 32'd0); imemreq1_val = 1'b1; cycle();
    dmemreq_msg  = mk(1'b1, 32'(4*DEPTH), 2'd0, 32'hFFFFFFFF); dmemreq_val = 1'b1; cycle();
    dmemreq_msg  = mk(1'b0, 32'(4*DEPTH), 2'd0, 32'd0); dmemreq_val = 1'b1; cycle();
    imemreq0_msg = mk(1'b0, 32'h0, 2'd0, 32'd0); imemreq0_val = 1'b1; cycle();
    idle(LAT + 1);

    // Reset with responses in flight
    imemreq0_msg = mk(1'b0, 32'h4, 2'd0, 32'd0); imemreq0_val = 1'b1; cycle();
    imemreq0_msg = mk(1'b0, 32'h8, 2'd0, 32'd0); imemreq0_val = 1'b1; cycle();
    #2 reset = 1'b0;
    #1;
    check("rst_resp0_val", 64'(imemresp0_val), 64'd0);
    check("rst_rdy0",      64'(imemreq0_rdy),  64'd0);
    check("rst_oob",       64'(oob_err),       64'd0);
    for (int p = 0; p < 3; p++) sbq[p].delete();
    exp_oob = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(LAT + 1);
    imemreq0_msg = mk(1'b0, 32'h100, 2'd0, 32'd0); imemreq0_val = 1'b1;
    dmemreq_msg  = mk(1'b0, 32'h200, 2'd0, 32'd0); dmemreq_val  = 1'b1;
    cycle();
    idle(LAT + 1);

    for (int p = 0; p < 3; p++) check($sformatf("drain_p%0d", p), 64'(sbq[p].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
